// File: rtl/tile_pkg.sv
// Shared definitions for the tile scheduler and the tile engine.
// Holds the FSM state type and the helper functions that derive the tile
// count and the index and extent widths from N and M. Both sides of the
// engine interface size their ports with these functions, so the widths
// always match.
package tile_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Tiles per dimension. Uses the ceiling so that a partial edge tile still
  // gets its own index.
  function automatic int tiles(input int n, input int m);
    return ceil_div(n, m);
  endfunction

  // Tile index width. It is never 0, so a single-tile build still has a
  // usable 1-bit index.
  function automatic int idx_w(input int t);
    return (t <= 1) ? 1 : $clog2(t);
  endfunction

  // Tile extent width. It must be able to hold the value M itself.
  function automatic int ext_w(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tile_index_counter.sv
// Three-digit base-T counter that walks the (ti, tj, tk) tile triples.
// tk is the least significant digit, then tj, then ti. Each digit wraps from
// T-1 to 0 and carries into the next digit.
// Ports:
//   clk, rst              clock and asynchronous active-high reset
//   clr_i                 force all digits to 0 (takes priority over adv_i)
//   adv_i                 step to the next triple
//   ti_o, tj_o, tk_o      registered digits
//   ti_nxt_o .. tk_nxt_o  next-state digits, so the parent can precompute
//                         values that depend on the index
//   last_o                the current triple is (T-1, T-1, T-1)
module tile_index_counter #(
  parameter int T  = 3,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [TW-1:0] ti_o,
  output logic [TW-1:0] tj_o,
  output logic [TW-1:0] tk_o,
  output logic [TW-1:0] ti_nxt_o,
  output logic [TW-1:0] tj_nxt_o,
  output logic [TW-1:0] tk_nxt_o,
  output logic          last_o
);

  localparam logic [TW-1:0] LAST = TW'(T - 1);

  logic [TW-1:0] ti_q, tj_q, tk_q;
  logic [TW-1:0] ti_d, tj_d, tk_d;
  logic          tk_wrap, tj_wrap, ti_wrap;

  // Wrap flags are chained: a digit wraps on the next advance only when every
  // less significant digit is also at T-1.
  assign tk_wrap = (tk_q == LAST);
  assign tj_wrap = tk_wrap && (tj_q == LAST);
  assign ti_wrap = tj_wrap && (ti_q == LAST);
  assign last_o  = ti_wrap;

  always_comb begin
    ti_d = ti_q;
    tj_d = tj_q;
    tk_d = tk_q;
    if (clr_i) begin
      ti_d = '0;
      tj_d = '0;
      tk_d = '0;
    end else if (adv_i) begin
      tk_d = tk_wrap ? '0 : tk_q + 1'b1;
      if (tk_wrap) tj_d = (tj_q == LAST) ? '0 : tj_q + 1'b1;
      if (tj_wrap) ti_d = ti_wrap ? '0 : ti_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ti_q <= '0;
      tj_q <= '0;
      tk_q <= '0;
    end else begin
      ti_q <= ti_d;
      tj_q <= tj_d;
      tk_q <= tk_d;
    end
  end

  assign ti_o     = ti_q;
  assign tj_o     = tj_q;
  assign tk_o     = tk_q;
  assign ti_nxt_o = ti_d;
  assign tj_nxt_o = tj_d;
  assign tk_nxt_o = tk_d;

endmodule

// File: rtl/tile_mult_scheduler.sv
// Sequences a blocked N x N matrix product onto a single M x M tile engine.
// It issues one engine job for each (ti, tj, tk) tile triple. With each job it
// sends the valid extents of the edge tiles and the accumulator clear and
// write-back flags.
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   start, abort     host control: start a run, cancel a run
//   busy             high while a run is in progress
//   done, aborted    one-cycle completion and cancellation pulses
//   eng_start        one-cycle job issue pulse to the engine
//   eng_done         job-complete pulse from the engine
//   eng_ti/tj/tk     tile indices of the current job
//   eng_rows/cols/depth   valid extents of the tiles in the current job
//   eng_acc_clr      job is the first of its reduction (tk == 0)
//   eng_acc_wb       job is the last of its reduction (tk == T-1)
//   jobs_done        number of jobs completed in the current or last run
module tile_mult_scheduler
  import tile_pkg::*;
#(
  parameter  int N  = 10,
  parameter  int M  = 4,
  localparam int T  = tiles(N, M),
  localparam int TW = idx_w(T),
  localparam int SW = ext_w(M)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          eng_start,
  input  logic          eng_done,
  output logic [TW-1:0] eng_ti,
  output logic [TW-1:0] eng_tj,
  output logic [TW-1:0] eng_tk,
  output logic [SW-1:0] eng_rows,
  output logic [SW-1:0] eng_cols,
  output logic [SW-1:0] eng_depth,
  output logic          eng_acc_clr,
  output logic          eng_acc_wb,
  output logic [3*TW:0] jobs_done
);

  localparam int            JW   = 3 * TW + 1;
  localparam logic [TW-1:0] LAST = TW'(T - 1);

  // Number of valid rows, cols or depth in the tile at index idx. Only the
  // final tile along a dimension can be shorter than M, and it is never empty.
  function automatic logic [SW-1:0] extent(input logic [TW-1:0] idx);
    int rem;
    rem = N - int'(idx) * M;
    return (rem >= M) ? SW'(M) : SW'(rem);
  endfunction

  state_t        state_q;
  logic          busy_q, done_q, aborted_q, eng_start_q;
  logic [SW-1:0] rows_q, cols_q, depth_q;
  logic          acc_clr_q, acc_wb_q;
  logic [JW-1:0] jobs_q;

  logic [TW-1:0] ti, tj, tk, ti_nxt, tj_nxt, tk_nxt;
  logic          last;
  logic          cnt_clr, cnt_adv;

  // The counter is cleared on an accepted start. It advances only on an
  // accepted eng_done that is not the final job and has not lost to abort.
  assign cnt_clr = (state_q == IDLE) && start;
  assign cnt_adv = (state_q == WAIT) && eng_done && !abort && !last;

  tile_index_counter #(
    .T  (T),
    .TW (TW)
  ) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .adv_i    (cnt_adv),
    .ti_o     (ti),
    .tj_o     (tj),
    .tk_o     (tk),
    .ti_nxt_o (ti_nxt),
    .tj_nxt_o (tj_nxt),
    .tk_nxt_o (tk_nxt),
    .last_o   (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      eng_start_q <= 1'b0;
      rows_q      <= '0;
      cols_q      <= '0;
      depth_q     <= '0;
      acc_clr_q   <= 1'b0;
      acc_wb_q    <= 1'b0;
      jobs_q      <= '0;
    end else begin
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      eng_start_q <= 1'b0;

      // Extents and flags are loaded from the counter's next index. They are
      // then valid in the ISSUE cycle together with the index registers.
      if (cnt_clr || cnt_adv) begin
        rows_q    <= extent(ti_nxt);
        cols_q    <= extent(tj_nxt);
        depth_q   <= extent(tk_nxt);
        acc_clr_q <= (tk_nxt == '0);
        acc_wb_q  <= (tk_nxt == LAST);
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            jobs_q      <= '0;
            busy_q      <= 1'b1;
            eng_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (abort) begin
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // When abort and eng_done arrive together, abort wins and the job
          // is not counted.
          if (abort) begin
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (eng_done) begin
            jobs_q <= jobs_q + JW'(1);
            if (last) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= FINISH;
            end else begin
              eng_start_q <= 1'b1;
              state_q     <= ISSUE;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign eng_start   = eng_start_q;
  assign eng_ti      = ti;
  assign eng_tj      = tj;
  assign eng_tk      = tk;
  assign eng_rows    = rows_q;
  assign eng_cols    = cols_q;
  assign eng_depth   = depth_q;
  assign eng_acc_clr = acc_clr_q;
  assign eng_acc_wb  = acc_wb_q;
  assign jobs_done   = jobs_q;

endmodule
